// File: rtl/control_unit_if.sv
// Bus bundle between the control unit and its instruction memory,
// data memory and combinational ALU. The control unit is the master.
interface control_unit_if #(
    parameter int ALU_BIT_WIDTH        = 4,
    parameter int OPERATION_CODE_WIDTH = 3
);
    // Instruction memory port
    logic [ALU_BIT_WIDTH-1:0]        pc_o;
    logic                            imem_req_o;
    logic                            imem_ack_i;
    logic [ALU_BIT_WIDTH+3:0]        instr_i;

    // Data memory port
    logic                            dmem_req_o;
    logic                            dmem_we_o;
    logic [ALU_BIT_WIDTH-1:0]        dmem_addr_o;
    logic [ALU_BIT_WIDTH-1:0]        dmem_wdata_o;
    logic                            dmem_ack_i;
    logic [ALU_BIT_WIDTH-1:0]        dmem_rdata_i;

    // ALU port
    logic [ALU_BIT_WIDTH-1:0]        alu_a_o;
    logic [ALU_BIT_WIDTH-1:0]        alu_b_o;
    logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o;
    logic [ALU_BIT_WIDTH-1:0]        alu_result_i;
    logic                            alu_carry_i;

    modport master (
        output pc_o, imem_req_o,
        input  imem_ack_i, instr_i,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i,
        output alu_a_o, alu_b_o, alu_oc_o,
        input  alu_result_i, alu_carry_i
    );

    modport slave (
        input  pc_o, imem_req_o,
        output imem_ack_i, instr_i,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i,
        input  alu_a_o, alu_b_o, alu_oc_o,
        output alu_result_i, alu_carry_i
    );
endinterface

// File: rtl/control_unit.sv
// Sequencer for the 4-bit CPU: fetch, decode, data-memory access and
// execute, one instruction at a time. The ALU is combinational and is
// sampled only in EXEC.
//
// Handshake: a request (imem_req_o / dmem_req_o) is held high, with its
// address and write data stable, until the matching ack is seen on a
// rising edge; the transfer completes on that edge and the request drops
// the next cycle. Acks seen while the matching request is low are ignored.
module control_unit #(
    parameter int ALU_BIT_WIDTH        = 4,
    parameter int OPERATION_CODE_WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    control_unit_if.master           bus,
    output logic [ALU_BIT_WIDTH-1:0] acc_o,
    output logic                     carry_o,
    output logic                     halted_o,
    output logic [2:0]               state_o
);
    localparam int W = ALU_BIT_WIDTH;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADD1 = 4'b0101;
    localparam logic [3:0] OP_SUB1 = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_LDA  = 4'b1000;
    localparam logic [3:0] OP_STA  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_JC   = 4'b1011;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t         state;
    logic [W-1:0]   pc;
    logic [W+3:0]   ir;
    logic [W-1:0]   operand;
    logic [W-1:0]   acc;
    logic           carry;
    logic           imem_req;
    logic           dmem_req;
    logic           dmem_we;
    logic           halted;

    logic [3:0]     opcode;
    logic [W-1:0]   ir_arg;
    logic           needs_mem;

    assign opcode = ir[W+3:W];
    assign ir_arg = ir[W-1:0];
    assign needs_mem = (opcode == OP_XOR) || (opcode == OP_AND) ||
                       (opcode == OP_OR)  || (opcode == OP_ADD) ||
                       (opcode == OP_SUB) || (opcode == OP_LDA) ||
                       (opcode == OP_STA);

    // Sequencer: state, architectural registers and registered requests
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            operand  <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            imem_req <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.imem_ack_i) begin
                        ir       <= bus.instr_i;
                        pc       <= pc + 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (needs_mem) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (opcode == OP_STA);
                        state    <= S_MEM;
                    end else if (opcode == OP_HLT) begin
                        halted   <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        state    <= S_EXEC;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack_i) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (opcode == OP_STA) begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            operand  <= bus.dmem_rdata_i;
                            state    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // ALU ops are 0001-0111; only 01xx touch the carry flag
                    if (!opcode[3] && (opcode != OP_NOP)) begin
                        acc <= bus.alu_result_i;
                        if (opcode[3:2] == 2'b01) begin
                            carry <= bus.alu_carry_i;
                        end
                    end else if (opcode == OP_LDA) begin
                        acc <= operand;
                    end else if (opcode == OP_JMP) begin
                        pc <= ir_arg;
                    end else if ((opcode == OP_JC) && carry) begin
                        pc <= ir_arg;
                    end
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    imem_req <= 1'b1;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

    // Bus and status outputs; ALU operands are live in every state
    always_comb begin
        bus.pc_o         = pc;
        bus.imem_req_o   = imem_req;
        bus.dmem_req_o   = dmem_req;
        bus.dmem_we_o    = dmem_we;
        bus.dmem_addr_o  = ir_arg;
        bus.dmem_wdata_o = acc;
        bus.alu_a_o      = acc;
        bus.alu_b_o      = ((opcode == OP_ADD1) || (opcode == OP_SUB1)) ?
                           {{(W-1){1'b0}}, 1'b1} : operand;
        bus.alu_oc_o     = ir[W +: OPERATION_CODE_WIDTH];
        acc_o            = acc;
        carry_o          = carry;
        halted_o         = halted;
        state_o          = state;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Sequencer for the 4-bit CPU. It fetches 8-bit instructions, decodes them, and performs data-memory handshakes. It drives the combinational ALU as that unit's initiator: it supplies operands and the 3-bit operation code, then captures result and carry into the accumulator and carry flag. It sits between instruction memory, data memory and the ALU, and executes one instruction at a time.

Parameters:
ALU_BIT_WIDTH, 4, datapath, accumulator, operand, PC and data-address width; instruction width is 4+ALU_BIT_WIDTH
OPERATION_CODE_WIDTH, 3, width of alu_oc_o

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_ni  input  1  synchronous active-low reset
pc_o  output  ALU_BIT_WIDTH  instruction address
imem_req_o  output  1  instruction fetch request
imem_ack_i  input  1  instruction valid this cycle
instr_i  input  4+ALU_BIT_WIDTH  instruction word: [7:4] opcode, [3:0] operand
dmem_req_o  output  1  data access request
dmem_we_o  output  1  1 = write, 0 = read; valid with dmem_req_o
dmem_addr_o  output  ALU_BIT_WIDTH  data address (IR operand)
dmem_wdata_o  output  ALU_BIT_WIDTH  write data (accumulator)
dmem_ack_i  input  1  access complete; rdata valid this cycle
dmem_rdata_i  input  ALU_BIT_WIDTH  read data
alu_a_o  output  ALU_BIT_WIDTH  ALU operand a (accumulator)
alu_b_o  output  ALU_BIT_WIDTH  ALU operand b (operand register, or 1 for ADD1/SUB1)
alu_oc_o  output  OPERATION_CODE_WIDTH  ALU operation code = IR opcode[2:0]
alu_result_i  input  ALU_BIT_WIDTH  ALU result
alu_carry_i  input  1  ALU carry/borrow
acc_o  output  ALU_BIT_WIDTH  accumulator
carry_o  output  1  carry flag
halted_o  output  1  high in HALT state

Behaviour:
- Reset (rst_ni low at an edge):
  - state=FETCH; pc, IR, operand register, acc, carry = 0; halted_o=0.
  - Requests follow state, so imem_req_o=1 after reset and dmem_req_o=dmem_we_o=0.
  - Reset mid-handshake abandons the transfer. An ack in the reset cycle is ignored.
- Opcodes:
  - 0000 NOP
  - 0001 XOR mem; 0010 AND mem; 0011 OR mem
  - 0100 ADD mem; 0101 ADD 1; 0110 SUB 1; 0111 SUB mem
  - 1000 LDA mem; 1001 STA mem
  - 1010 JMP op; 1011 JC op
  - 1111 HLT
  - 1100-1110 behave as NOP.
- FETCH:
  - imem_req_o=1; held, with pc_o stable, until imem_ack_i.
  - On ack: IR<=instr_i, pc<=pc+1 (wraps 15->0), go to DECODE.
- DECODE (1 cycle):
  - opcodes 0001-0100, 0111, 1000, 1001 -> MEM
  - HLT -> HALT
  - all others -> EXEC
- MEM:
  - dmem_req_o=1, dmem_addr_o=IR[3:0]; dmem_we_o=1 only for STA, with dmem_wdata_o=acc.
  - Held until dmem_ack_i.
  - On ack, STA -> FETCH.
  - On ack, all others: operand<=dmem_rdata_i -> EXEC.
- EXEC (1 cycle), then FETCH:
  - ALU ops (0001-0111): acc<=alu_result_i.
  - Arithmetic ops (0100-0111) also set carry<=alu_carry_i; logic ops leave carry unchanged.
  - LDA: acc<=operand; carry unchanged.
  - JMP: pc<=IR[3:0].
  - JC: pc<=IR[3:0] if carry=1, else no change.
  - NOP/undefined: no change.
- HALT: terminal; only reset leaves it; no requests issued; halted_o=1.
- Output driving:
  - alu_a_o, alu_b_o and alu_oc_o are driven combinationally from acc, operand/constant and IR in every state; the ALU result is only sampled in EXEC.
  - imem_req_o and dmem_req_o are never high simultaneously.
  - Acks arriving outside the matching state are ignored.
- Latency with zero-wait acks (ack in the first request cycle):
  - memory-operand op: 4 cycles
  - STA: 3 cycles
  - register/jump op: 3 cycles
  - each extra wait cycle on an ack adds 1.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with ack stimulus active -> acc=0, carry=0, pc_o=0, halted_o=0, dmem_req_o=0, imem_req_o=1 after release.
- Program LDA 0; ADD 1(mem); STA 2; HLT with dmem[0]=1, dmem[1]=2, zero-wait acks -> acc=3, carry=0, dmem write addr 2 data 3, halted_o=1 after 4+4+3+2 cycles, pc_o=4.
- Carry and jump: LDA with mem=15; ADD1 -> acc=0, carry=1; JC 7 -> pc_o=7. Same with mem=14 -> acc=15, carry=0, JC falls through to pc_o=3.
- Logic ops preserve carry: carry=1, acc=0001, XOR mem=0010 -> acc=0011; AND mem=0010 -> acc=0010; OR mem=0001 -> acc=0011; carry remains 1 throughout; alu_oc_o=001/010/011 in the respective EXEC cycles.
- Wait states: imem_ack_i delayed 3 cycles and dmem_ack_i delayed 2 cycles on ADD mem -> requests held with stable pc_o/dmem_addr_o, instruction completes in 4+3+2=9 cycles with correct acc.
- Reset mid-MEM: assert rst_ni=0 while dmem_req_o=1 and dmem_ack_i=1 -> no acc update, dmem_req_o=0 next cycle, state restarts at FETCH with pc_o=0.
